// File: rtl/vbw_accumulator_if.sv
// vbw_accumulator_if: burst accumulator bus (start/mode/len control, in_valid/in_ready/in_data, out_valid/out_ready/out_data/out_ovf, busy)
interface vbw_accumulator_if #(parameter int LEN_W = 8);
  logic             start;
  logic [1:0]       mode;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [63:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_data;
  logic [7:0]       out_ovf;
  logic             busy;
  modport master (
    output start, mode, len, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, busy
  );
  modport slave (
    input  start, mode, len, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ovf, busy
  );
endinterface

// File: rtl/vbw_accumulator.sv
// vbw_accumulator: lane-partitioned 64-bit burst accumulator; ports clk, rst (sync active-high), bus (slave: start/mode/len in, in_valid/in_data in, in_ready out, out_valid/out_data/out_ovf/busy out, out_ready in)
module vbw_accumulator #(
  parameter int LEN_W = 8
) (
  input logic              clk,
  input logic              rst,
  vbw_accumulator_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t           state_q;
  logic [1:0]       mode_q;
  logic [LEN_W-1:0] len_q, cnt_q;
  logic [63:0]      acc_q, acc_d;
  logic [7:0]       ovf_q, ovf_d, top, cy_o;
  logic             in_ready_q, out_valid_q, busy_q, cy;
  logic [8:0]       t;
  always_comb begin
    top = mode_q == 2'b00 ? 8'h80 : mode_q == 2'b01 ? 8'h88 : mode_q == 2'b10 ? 8'hAA : 8'hFF;
    acc_d = '0;
    cy_o = '0;
    cy = 1'b0;
    t = '0;
    for (int k = 0; k < 8; k++) begin
      t = {1'b0, acc_q[8*k+:8]} + {1'b0, bus.in_data[8*k+:8]} + {8'd0, cy};
      acc_d[8*k+:8] = t[7:0];
      cy_o[k] = t[8];
      cy = t[8] & ~top[k];
    end
    ovf_d = ovf_q | (cy_o & top);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
      acc_q <= '0;
      ovf_q <= '0;
      in_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          mode_q <= bus.mode;
          len_q <= bus.len;
          cnt_q <= '0;
          acc_q <= '0;
          ovf_q <= '0;
          busy_q <= 1'b1;
          in_ready_q <= bus.len != '0;
          out_valid_q <= bus.len == '0;
          state_q <= bus.len != '0 ? ACCUM : DONE;
        end
        ACCUM: if (bus.in_valid && in_ready_q) begin
          acc_q <= acc_d;
          ovf_q <= ovf_d;
          cnt_q <= cnt_q + LEN_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) begin
            in_ready_q <= 1'b0;
            out_valid_q <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          busy_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.in_ready = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy = busy_q;
  assign bus.out_data = acc_q;
  assign bus.out_ovf = ovf_q;
endmodule

// File: tb/tb_vbw_accumulator.sv
// tb_vbw_accumulator: directed table-driven bench for vbw_accumulator
module tb_vbw_accumulator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  vbw_accumulator_if #(.LEN_W(8)) bus();
  vbw_accumulator #(.LEN_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct packed {
    logic [1:0]       mode;
    logic [7:0]       len;
    logic [3:0][63:0] beats;
    logic [63:0]      exp_data;
    logic [7:0]       exp_ovf;
  } vec_t;
  vec_t vecs[8];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic release_result(input string name);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({name, " valid_after_ready"}, 64'(bus.out_valid), 64'd0);
    chk({name, " busy_after_ready"}, 64'(bus.busy), 64'd0);
  endtask
  task automatic burst(input string name, input vec_t v);
    int lat;
    int i;
    bus.start = 1'b1;
    bus.mode = v.mode;
    bus.len = v.len;
    tick();
    bus.start = 1'b0;
    lat = 1;
    i = 0;
    while (!bus.out_valid && lat < 100) begin
      bus.in_valid = bus.in_ready;
      bus.in_data = i < 4 ? v.beats[i] : 64'd0;
      tick();
      if (bus.in_valid) i++;
      lat++;
    end
    bus.in_valid = 1'b0;
    chk({name, " latency"}, 64'(lat), 64'(v.len) + 64'd1);
    chk({name, " beats"}, 64'(i), 64'(v.len));
    chk({name, " out_data"}, bus.out_data, v.exp_data);
    chk({name, " out_ovf"}, 64'(bus.out_ovf), 64'(v.exp_ovf));
    release_result(name);
  endtask
  initial begin
    int pat[7];
    logic [63:0] held;
    vecs[0] = '{mode: 2'b00, len: 8'd2, beats: {64'd0, 64'd0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF}, exp_data: 64'h0, exp_ovf: 8'h80};
    vecs[1] = '{mode: 2'b11, len: 8'd3, beats: {64'd0, {3{64'h8080_8080_8080_8080}}}, exp_data: 64'h8080_8080_8080_8080, exp_ovf: 8'hFF};
    vecs[2] = '{mode: 2'b01, len: 8'd1, beats: {64'd0, 64'd0, 64'd0, 64'h0000_0001_FFFF_FFFF}, exp_data: 64'h0000_0001_FFFF_FFFF, exp_ovf: 8'h00};
    vecs[3] = '{mode: 2'b01, len: 8'd2, beats: {64'd0, 64'd0, 64'h0000_0001_FFFF_FFFF, 64'hFFFF_FFFF_0000_0001}, exp_data: 64'h0, exp_ovf: 8'h88};
    vecs[4] = '{mode: 2'b00, len: 8'd0, beats: {4{64'hDEAD_BEEF_DEAD_BEEF}}, exp_data: 64'h0, exp_ovf: 8'h00};
    vecs[5] = '{mode: 2'b10, len: 8'd2, beats: {64'd0, 64'd0, 64'h8000_0001_FFFF_0001, 64'h8000_FFFF_0001_1234}, exp_data: 64'h0000_0000_0000_1235, exp_ovf: 8'hA8};
    vecs[6] = '{mode: 2'b11, len: 8'd2, beats: {64'd0, 64'd0, 64'h0001_0000_0000_00FF, 64'h00FF_0000_0000_0001}, exp_data: 64'h0, exp_ovf: 8'h41};
    vecs[7] = '{mode: 2'b00, len: 8'd2, beats: {64'd0, 64'd0, 64'h1, 64'h0000_0000_FFFF_FFFF}, exp_data: 64'h0000_0001_0000_0000, exp_ovf: 8'h00};
    pat = '{1, 0, 0, 1, 1, 0, 1};
    bus.start = 1'b0;
    bus.mode = 2'b00;
    bus.len = '0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset in_ready", 64'(bus.in_ready), 64'd0);
    chk("reset out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset out_data", bus.out_data, 64'd0);
    chk("reset out_ovf", 64'(bus.out_ovf), 64'd0);
    for (int v = 0; v < 8; v++) burst($sformatf("vec%0d", v), vecs[v]);
    bus.start = 1'b1;
    bus.mode = 2'b10;
    bus.len = 8'd4;
    tick();
    bus.start = 1'b0;
    for (int c = 0; c < 7; c++) begin
      chk($sformatf("stall in_ready c%0d", c), 64'(bus.in_ready), 64'd1);
      chk($sformatf("stall out_valid c%0d", c), 64'(bus.out_valid), 64'd0);
      bus.in_valid = pat[c] != 0;
      bus.in_data = 64'h0001_0002_0003_4000;
      tick();
    end
    bus.in_valid = 1'b0;
    chk("stall out_valid", 64'(bus.out_valid), 64'd1);
    chk("stall out_data", bus.out_data, 64'h0004_0008_000C_0000);
    chk("stall out_ovf", 64'(bus.out_ovf), 64'h02);
    release_result("stall");
    bus.start = 1'b1;
    bus.mode = 2'b00;
    bus.len = 8'd4;
    tick();
    bus.start = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 64'hFF;
    tick();
    bus.start = 1'b1;
    bus.mode = 2'b11;
    bus.len = 8'd1;
    bus.in_data = 64'h01;
    tick();
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    chk("busy start in_ready", 64'(bus.in_ready), 64'd1);
    chk("busy start out_valid", 64'(bus.out_valid), 64'd0);
    chk("busy start out_data", bus.out_data, 64'h100);
    chk("busy start out_ovf", 64'(bus.out_ovf), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst busy", 64'(bus.busy), 64'd0);
    chk("midrst in_ready", 64'(bus.in_ready), 64'd0);
    chk("midrst out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst out_data", bus.out_data, 64'd0);
    bus.start = 1'b1;
    bus.mode = 2'b11;
    bus.len = 8'd1;
    tick();
    bus.start = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 64'h0102_0304_0506_0708;
    tick();
    bus.in_valid = 1'b0;
    held = 64'h0102_0304_0506_0708;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("hold out_valid c%0d", c), 64'(bus.out_valid), 64'd1);
      chk($sformatf("hold out_data c%0d", c), bus.out_data, held);
      tick();
    end
    release_result("hold");
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
